pipeline_exec_ctrl: RTL and testbench
=====================================

// Module: pipeline_exec_ctrl
// PURPOSE
// - Run/step/halt sequencer for the 5-stage MIPS pipeline. Owns the global pipeline enable that gates PC and every stage register.
// - Sits between the debug command source and the datapath, alongside the hazard unit.
// - Final PC write = hazard PCWrite & pipe_en & ~pc_hold.
// - Drains the pipeline when HALT reaches ID, then reports completion.
// - Counts executed cycles for the debug unit.
// PARAMETERS
// - DRAIN_CYCLES  3   cycles after HALT is seen in ID until HALT retires from WB
// - CNT_W         32  width of the executed-cycle counter
// - PC_W          32  PC width, used by the breakpoint compare only
// PORTS
// - clk          in   1      single clock; all state updates on the rising edge
// - rst_n        in   1      asynchronous, active-low reset
// - cmd_valid    in   1      command strobe
// - cmd_code     in   2      00 STOP, 01 RUN, 10 STEP, 11 CLEAR
// - cmd_ready    out  1      command accepted when cmd_valid & cmd_ready
// - cmd_err      out  1      1-cycle pulse: command rejected in the current state
// - halt_id      in   1      HALT opcode decoded in the IF/ID stage
// - pc_if        in   PC_W   current fetch PC
// - bp_valid     in   1      breakpoint armed
// - bp_addr      in   PC_W   breakpoint PC
// - pipe_en      out  1      global enable for PC and all pipeline registers
// - pc_hold      out  1      freeze PC (ANDed with hazard PCWrite)
// - ifid_nop     out  1      load a NOP into IF/ID on the next enabled edge
// - pipe_flush   out  1      synchronous clear of all pipeline registers
// - done         out  1      1-cycle pulse: drain complete
// - bp_hit       out  1      1-cycle pulse: breakpoint reached
// - state_o      out  3      current state encoding, for debug readout
// - cycle_cnt    out  CNT_W  cycles with pipe_en=1, saturating
// BEHAVIOUR
// - Reset (async, any state, including mid-drain): state=IDLE, drain counter=0, cycle_cnt=0; every 1-bit output=0.
// - States and encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4, FLUSH=5.
// - cmd_ready: 1 in IDLE, RUN and HALTED; 0 in STEP, DRAIN and FLUSH.
// - IDLE (pipe_en=0):
//   - RUN -> RUN.
//   - STEP -> STEP, or -> DRAIN when halt_id=1 on the accepting cycle.
//   - CLEAR -> FLUSH.
//   - STOP accepted as a no-op.
// - RUN (pipe_en=1):
//   - STOP -> IDLE. The accepting cycle still has pipe_en=1.
//   - RUN, STEP and CLEAR are rejected: cmd_err=1, state unchanged.
//   - halt_id=1 -> DRAIN. That same cycle pc_hold=1 and ifid_nop=1, combinationally.
//   - halt_id and STOP on the same cycle: halt wins; STOP is rejected with cmd_err=1.
// - STEP: exactly one cycle with pipe_en=1, then -> IDLE. halt_id is sampled in IDLE before entry.
// - DRAIN (pipe_en=1, pc_hold=1, ifid_nop=1):
//   - Runs exactly DRAIN_CYCLES cycles, counted 0..DRAIN_CYCLES-1, then -> HALTED.
//   - done=1 on the first HALTED cycle.
//   - Incoming commands are not accepted (cmd_ready=0).
// - HALTED (pipe_en=0):
//   - CLEAR -> FLUSH.
//   - STOP is a no-op.
//   - RUN and STEP are rejected with cmd_err=1.
// - FLUSH: one cycle with pipe_flush=1 and pipe_en=0; cycle_cnt cleared; then -> IDLE.
// - cycle_cnt: +1 on every cycle with pipe_en=1; holds at 2^CNT_W-1; cleared only by reset or FLUSH.
// - Latency: the command is accepted at edge N; the new state and its outputs are valid after edge N.
// - halt_id is ignored in STEP, DRAIN, HALTED and FLUSH.
// CONFIGURATION
// - PIPE_CTRL_BREAKPOINT_EN defined:
//   - In RUN with bp_valid=1 and pc_if==bp_addr: pipe_en=0 and bp_hit=1 that cycle, -> IDLE.
//   - halt_id has priority over the breakpoint.
//   - The first RUN cycle after acceptance ignores a match, so RUN resumes from a breakpoint.
// - PIPE_CTRL_BREAKPOINT_EN undefined: bp_valid, bp_addr and pc_if are ignored; bp_hit is tied to 0.
// TESTING
// - STEP x3 from IDLE, no halt -> three isolated 1-cycle pipe_en pulses; cycle_cnt=3; state returns to 0 each time.
// - RUN, halt_id=1 at cycle 10 -> pc_hold=1 and ifid_nop=1 for 4 cycles (10..13); done pulse at cycle 14; state=4; cycle_cnt=14.
// - In HALTED, RUN -> cmd_err=1. Then CLEAR -> pipe_flush=1 for 1 cycle, cycle_cnt=0, state=0.
// - RUN, then STOP with halt_id=1 on the same cycle -> cmd_err=1 and enter DRAIN. Repeat with halt_id=0 -> IDLE, no cmd_err.
// - rst_n low for 1 cycle during DRAIN cycle 2 -> all outputs 0 and state=0 immediately, without waiting for a clock edge; done never pulses.
// - PIPE_CTRL_BREAKPOINT_EN, bp_addr=0x20, RUN from pc=0 with 4-byte steps -> bp_hit at pc_if=0x20, pipe_en=0, state=0.
//   - A second RUN -> passes 0x20 and continues.

Source files
------------

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/halt sequencer for the 5-stage pipeline: owns the global pipeline enable,
// drains on HALT, counts enabled cycles. Breakpoint stop is built with PIPE_CTRL_BREAKPOINT_EN.
module pipeline_exec_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32,
  parameter int PC_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  output logic             cmd_ready,
  output logic             cmd_err,
  input  logic             halt_id,
  input  logic [PC_W-1:0]  pc_if,
  input  logic             bp_valid,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             pipe_en,
  output logic             pc_hold,
  output logic             ifid_nop,
  output logic             pipe_flush,
  output logic             done,
  output logic             bp_hit,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt
);

  // state  | meaning
  // IDLE   | pipeline frozen, waiting for a command
  // RUN    | free-running until STOP, HALT in ID or breakpoint
  // STEP   | single enabled cycle, then back to IDLE
  // DRAIN  | HALT seen in ID, PC frozen, letting it retire from WB
  // HALTED | drain complete, only CLEAR leaves
  // FLUSH  | one-cycle clear of all pipeline registers and the counter
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;
  localparam logic [2:0] S_FLUSH  = 3'd5;

  localparam logic [1:0] C_STOP  = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_STEP  = 2'd2;
  localparam logic [1:0] C_CLEAR = 2'd3;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cmd_ready_q, cmd_ready_d;
  logic             cmd_err_q, cmd_err_d;
  logic             done_q, done_d;
  logic             run_first_q, run_first_d;
  logic             accept;
  logic             bp_match;

  assign accept = cmd_valid & cmd_ready_q;

`ifdef PIPE_CTRL_BREAKPOINT_EN
  // HALT in ID outranks the breakpoint; the first RUN cycle skips it so RUN can resume past it.
  assign bp_match = (state_q == S_RUN) & bp_valid & (pc_if == bp_addr) & ~run_first_q & ~halt_id;
`else
  logic bp_unused;
  assign bp_unused = ^{bp_valid, bp_addr, pc_if, run_first_q};
  assign bp_match  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cmd_err_d   = 1'b0;
    done_d      = 1'b0;
    run_first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_code)
            C_RUN: begin
              state_d     = S_RUN;
              run_first_d = 1'b1;
            end
            C_STEP: begin
              state_d = halt_id ? S_DRAIN : S_STEP;
              drain_d = '0;
            end
            C_CLEAR: state_d = S_FLUSH;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (halt_id) begin
          state_d = S_DRAIN;
          drain_d = '0;
          if (accept) cmd_err_d = 1'b1;
        end else begin
          if (accept) begin
            if (cmd_code == C_STOP) state_d = S_IDLE;
            else cmd_err_d = 1'b1;
          end
          if (bp_match) state_d = S_IDLE;
        end
      end
      S_STEP:  state_d = S_IDLE;
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_HALTED;
          drain_d = '0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_HALTED: begin
        if (accept) begin
          if (cmd_code == C_CLEAR) state_d = S_FLUSH;
          else if (cmd_code != C_STOP) cmd_err_d = 1'b1;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered so it reads 0 while reset is applied.
  assign cmd_ready_d = (state_d == S_IDLE) | (state_d == S_RUN) | (state_d == S_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
      run_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_err_q   <= cmd_err_d;
      done_q      <= done_d;
      run_first_q <= run_first_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_FLUSH) begin
      cnt_q <= '0;
    end else if (pipe_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign pipe_en    = ((state_q == S_RUN) & ~bp_match) | (state_q == S_STEP) | (state_q == S_DRAIN);
  assign pc_hold    = (state_q == S_DRAIN) | ((state_q == S_RUN) & halt_id);
  assign ifid_nop   = pc_hold;
  assign pipe_flush = (state_q == S_FLUSH);
  assign done       = done_q;
  assign bp_hit     = bp_match;
  assign cmd_ready  = cmd_ready_q;
  assign cmd_err    = cmd_err_q;
  assign state_o    = state_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: directed scenarios then random stimulus,
// checked cycle by cycle against a behavioural model. Define PIPE_CTRL_BREAKPOINT_EN to cover breakpoints.
module tb_pipeline_exec_ctrl;
  localparam int CNT_W = 8;
  localparam int PC_W  = 32;
  localparam int DRAIN = 3;
`ifdef PIPE_CTRL_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4, M_FLUSH = 5;
  localparam logic [1:0] STOP = 2'd0, RUN = 2'd1, STEP = 2'd2, CLEAR = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_code = 2'd0;
  logic             halt_id = 1'b0;
  logic [PC_W-1:0]  pc_if = '0;
  logic             bp_valid = 1'b0;
  logic [PC_W-1:0]  bp_addr = '0;
  logic             cmd_ready, cmd_err, pipe_en, pc_hold, ifid_nop, pipe_flush, done, bp_hit;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] cycle_cnt;

  pipeline_exec_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .cmd_err(cmd_err), .halt_id(halt_id), .pc_if(pc_if),
    .bp_valid(bp_valid), .bp_addr(bp_addr), .pipe_en(pipe_en), .pc_hold(pc_hold),
    .ifid_nop(ifid_nop), .pipe_flush(pipe_flush), .done(done), .bp_hit(bp_hit),
    .state_o(state_o), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic ready, err, en, hold, nop, flush, done, bp;
  } obs_t;

  obs_t exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  logic [PC_W-1:0] tb_pc = '0;

  // Behavioural model state
  int m_mode = M_IDLE;
  int m_left = 0;
  int m_cnt  = 0;
  bit m_ready = 1'b0, m_err = 1'b0, m_done = 1'b0, m_fresh = 1'b0;

  function automatic obs_t sample();
    obs_t s;
    s.state = state_o;  s.cnt  = cycle_cnt; s.ready = cmd_ready; s.err  = cmd_err;
    s.en    = pipe_en;  s.hold = pc_hold;   s.nop   = ifid_nop;  s.flush = pipe_flush;
    s.done  = done;     s.bp   = bp_hit;
    return s;
  endfunction

  task automatic report(input string tag, input obs_t got, input obs_t e);
    $display("FAIL %s t=%0t got st=%0d cnt=%0d rdy=%b err=%b en=%b hold=%b nop=%b fl=%b dn=%b bp=%b, exp st=%0d cnt=%0d rdy=%b err=%b en=%b hold=%b nop=%b fl=%b dn=%b bp=%b",
             tag, $time, got.state, got.cnt, got.ready, got.err, got.en, got.hold, got.nop, got.flush, got.done, got.bp,
             e.state, e.cnt, e.ready, e.err, e.en, e.hold, e.nop, e.flush, e.done, e.bp);
  endtask

  // Expected outputs for this cycle, then advance the model across the next clock edge.
  task automatic model(input bit v, input logic [1:0] c, input bit h, input bit bpv,
                       input logic [PC_W-1:0] bpa, input logic [PC_W-1:0] pc, input bit rn,
                       output obs_t e);
    bit acc, halt_now, bp, en;
    int nmode;
    e = '0;
    if (!rn) begin
      m_mode = M_IDLE; m_left = 0; m_cnt = 0;
      m_ready = 1'b0; m_err = 1'b0; m_done = 1'b0; m_fresh = 1'b0;
      return;
    end
    acc      = v && m_ready;
    halt_now = (m_mode == M_RUN) && h;
    bp       = BP_EN && (m_mode == M_RUN) && !h && bpv && (pc == bpa) && !m_fresh;
    en       = ((m_mode == M_RUN) && !bp) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
    e.state = 3'(m_mode);
    e.cnt   = CNT_W'(m_cnt);
    e.ready = m_ready;
    e.err   = m_err;
    e.en    = en;
    e.hold  = (m_mode == M_DRAIN) || halt_now;
    e.nop   = e.hold;
    e.flush = (m_mode == M_FLUSH);
    e.done  = m_done;
    e.bp    = bp;

    nmode = m_mode; m_err = 1'b0; m_done = 1'b0; m_fresh = 1'b0;
    case (m_mode)
      M_IDLE: if (acc) begin
        if (c == RUN) begin nmode = M_RUN; m_fresh = 1'b1; end
        else if (c == STEP) begin
          if (h) begin nmode = M_DRAIN; m_left = DRAIN; end
          else nmode = M_STEP;
        end
        else if (c == CLEAR) nmode = M_FLUSH;
      end
      M_RUN: begin
        if (halt_now) begin
          nmode = M_DRAIN; m_left = DRAIN;
          if (acc) m_err = 1'b1;
        end else begin
          if (acc && c != STOP) m_err = 1'b1;
          if ((acc && c == STOP) || bp) nmode = M_IDLE;
        end
      end
      M_STEP: nmode = M_IDLE;
      M_DRAIN: begin
        m_left--;
        if (m_left == 0) begin nmode = M_HALTED; m_done = 1'b1; end
      end
      M_HALTED: if (acc) begin
        if (c == CLEAR) nmode = M_FLUSH;
        else if (c != STOP) m_err = 1'b1;
      end
      default: nmode = M_IDLE;
    endcase
    if (m_mode == M_FLUSH) m_cnt = 0;
    else if (en && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    m_mode  = nmode;
    m_ready = (nmode == M_IDLE) || (nmode == M_RUN) || (nmode == M_HALTED);
  endtask

  task automatic step(input bit v, input logic [1:0] c, input bit h, input bit bpv,
                      input logic [PC_W-1:0] bpa, input bit rn);
    obs_t e, got;
    @(posedge clk);
    #1;
    cmd_valid = v; cmd_code = c; halt_id = h; bp_valid = bpv; bp_addr = bpa;
    pc_if = tb_pc; rst_n = rn;
    model(v, c, h, bpv, bpa, tb_pc, rn, e);
    exp_q.push_back(e);
    if (!rn) begin
      #1;
      got = sample();
      n_vec++;
      if (got !== obs_t'('0)) begin
        n_miss++;
        report("async_reset", got, obs_t'('0));
      end
    end
    if (e.en && !e.hold) tb_pc = tb_pc + 32'd4;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, STOP, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic issue(input logic [1:0] c, input bit h);
    step(1'b1, c, h, 1'b0, '0, 1'b1);
  endtask

  always @(negedge clk) begin
    obs_t e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = sample();
      n_vec++;
      if (got !== e) begin
        n_miss++;
        report("cycle", got, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b0, STOP, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, STOP, 1'b0, 1'b0, '0, 1'b0);
    idle(2);

    for (int i = 0; i < 3; i++) begin
      issue(STEP, 1'b0);
      idle(2);
    end
    issue(CLEAR, 1'b0);
    idle(2);

    issue(RUN, 1'b0);
    idle(10);
    step(1'b0, STOP, 1'b1, 1'b0, '0, 1'b1);
    idle(5);
    issue(RUN, 1'b0);
    issue(STEP, 1'b0);
    issue(STOP, 1'b0);
    issue(CLEAR, 1'b0);
    idle(2);

    issue(RUN, 1'b0);
    idle(3);
    issue(STOP, 1'b1);
    idle(5);
    issue(CLEAR, 1'b0);
    idle(2);
    issue(RUN, 1'b0);
    idle(3);
    issue(STOP, 1'b0);
    idle(2);

    issue(RUN, 1'b0);
    idle(2);
    issue(RUN, 1'b0);
    issue(CLEAR, 1'b0);
    issue(STEP, 1'b0);
    step(1'b0, STOP, 1'b1, 1'b0, '0, 1'b1);
    idle(2);
    step(1'b0, STOP, 1'b0, 1'b0, '0, 1'b0);
    idle(6);

    issue(STEP, 1'b1);
    idle(5);
    issue(CLEAR, 1'b0);
    idle(2);

`ifdef PIPE_CTRL_BREAKPOINT_EN
    tb_pc = '0;
    step(1'b1, RUN, 1'b0, 1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, STOP, 1'b0, 1'b1, 32'h20, 1'b1);
    step(1'b1, RUN, 1'b0, 1'b1, 32'h20, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, STOP, 1'b0, 1'b1, 32'h20, 1'b1);
    issue(STOP, 1'b0);
    idle(2);
`endif

    issue(RUN, 1'b0);
    idle(300);
    issue(STOP, 1'b0);
    idle(2);
    issue(CLEAR, 1'b0);
    idle(2);

    for (int i = 0; i < 2500; i++) begin
      logic [PC_W-1:0] a;
      a = tb_pc + 32'(4 * $urandom_range(0, 6));
      step($urandom_range(0, 99) < 30, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 6,
           1'($urandom_range(0, 1)), a, $urandom_range(0, 199) != 0);
    end
    idle(3);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain_queue: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
